plazer_master_0_b2p: RTL and testbench
======================================

# plazer_master_0_b2p

Bytes-to-packets decoder for the PLazeR master's Avalon-ST command path. It consumes the raw 8-bit byte stream from the host transport and strips in-band control characters. It emits an Avalon-ST packet stream with data, channel, startofpacket and endofpacket. Its output feeds directly into the b2p channel adapter, which suppresses channels above its maximum.

## Interface
- CHANNEL_WIDTH, 8: width of `out_channel` and the internal channel register. The decoded channel byte is truncated to this width.
- clk  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_ready  out  1  byte sink ready
- in_valid  in  1  byte valid
- in_data  in  8  raw byte
- out_ready  in  1  downstream ready
- out_valid  out  1  packet beat valid (registered)
- out_data  out  8  decoded data byte (registered)
- out_channel  out  CHANNEL_WIDTH  channel of the beat (registered)
- out_startofpacket  out  1  first beat of packet (registered)
- out_endofpacket  out  1  last beat of packet (registered)

## Operation
- Control characters, applied only when not escaped:
  - 0x7A (SOP): sets `sop_flag`.
  - 0x7B (EOP): sets `eop_flag`.
  - 0x7C (CHAN): sets `chan_flag`.
  - 0x7D (ESC): sets `esc_flag`.
- Control characters produce no output beat.
- Accept means `in_valid && in_ready`. On accept of byte b:
  - If `esc_flag`: value = b ^ 0x20, clear `esc_flag`, and treat the value as an ordinary byte, even if it equals 0x7A–0x7D.
  - Else if b is in 0x7A–0x7D: update the flag as above and stop.
  - Else: value = b.
- Ordinary value handling:
  - If `chan_flag`: `channel_reg` <= value[CHANNEL_WIDTH-1:0], clear `chan_flag`, no output.
  - Else: load the output register with data=value, channel=`channel_reg`, sop=`sop_flag`, eop=`eop_flag`, valid=1. Clear `sop_flag` and `eop_flag` in the same cycle.
- `channel_reg` persists across packets until the next CHAN sequence.
- Repeated SOP or EOP markers before a data byte are idempotent; the flag simply stays set.
- EOP followed by SOP, then one data byte, gives a single beat with sop=1 and eop=1.
- SOP/EOP markers received while `chan_flag` or `esc_flag` is pending:
  - While `esc_flag` is set, the byte is escaped data, per the rules above.
  - While only `chan_flag` is set, 0x7A/0x7B set their flag and `chan_flag` stays pending.
- No packet-framing checks are made. Data with no preceding SOP is emitted with sop=0.

## Timing
- Reset (async assert, sync-safe deassert by the system) clears:
  - all outputs: out_valid=0, out_data=0, out_channel=0, out_startofpacket=0, out_endofpacket=0;
  - all flags and `channel_reg`.
- Reset mid-packet discards any pending beat and flags with no further output.
- `in_ready` = !out_valid || out_ready. This path is combinational from `out_ready`. While reset is asserted, `in_ready` = 1 because out_valid=0.
- Latency: a data byte accepted in cycle N appears on out_* in cycle N+1.
- Control bytes are consumed at one per cycle with no output.
- Throughput is one byte per cycle when `out_ready` is held high.
- Output handshake: the beat is transferred when out_valid && out_ready.
  - Transfer with no new data byte accepted in the same cycle: out_valid <= 0.
  - Transfer together with acceptance of a data byte: the register reloads and out_valid stays 1. There is no bubble.
- With out_valid=1 and out_ready=0:
  - in_ready=0;
  - out_* are held stable;
  - no flag changes, because no byte is accepted.
- out_data, out_channel, out_startofpacket and out_endofpacket change only on load or reset.

## Test plan
- Reset then stream 7A 7C 03 11 22 7B 33 with out_ready=1 -> beats (11,ch3,sop), (22,ch3), (33,ch3,eop). Each beat appears 1 cycle after its byte; none appear for control bytes.
- Escapes: 7A 7D 5A 7D 5D 7B 7D 5C -> beats (7A,sop), (7D), (7C,eop).
- Escaped channel: 7C 7D 5B 7A 7B 44 -> one beat, data 44, channel 0x7B, sop=1, eop=1.
- Backpressure: stream 7A 01 02 03 7B 04 while out_ready toggles 1,0,0,1,… randomly.
  - No byte is lost or duplicated; in_ready=0 exactly while out_valid && !out_ready; out_* are stable during stalls.
  - Full rate (one byte per cycle) is achieved with out_ready=1.
- Channel persistence: 7C 05 7A AA 7B BB, then 7A CC 7B DD -> all four beats carry ch5.
- Reset mid-operation: send 7A 7C, assert reset_n=0 for 2 cycles, then send 09 7B 0A.
  - After reset: beats (09, ch0, sop=0) and (0A, ch0, eop=1).
  - All outputs are 0 during reset.

Source files
------------

// File: rtl/plazer_master_0_b2p_if.sv
// Avalon-ST byte-in / packet-out bundle for the PLazeR master bytes-to-packets decoder.
// master: the decoder side; slave: the host transport and downstream adapter side.
interface plazer_master_0_b2p_if #(
  parameter int CHANNEL_WIDTH = 8
);
  logic                     in_ready;
  logic                     in_valid;
  logic [7:0]               in_data;
  logic                     out_ready;
  logic                     out_valid;
  logic [7:0]               out_data;
  logic [CHANNEL_WIDTH-1:0] out_channel;
  logic                     out_startofpacket;
  logic                     out_endofpacket;

  modport master (
    output in_ready,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_channel,
    output out_startofpacket,
    output out_endofpacket
  );

  modport slave (
    input  in_ready,
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_channel,
    input  out_startofpacket,
    input  out_endofpacket
  );
endinterface

// File: rtl/plazer_master_0_b2p.sv
// Bytes-to-packets decoder: strips SOP/EOP/CHAN/ESC control characters from the host
// byte stream and emits registered Avalon-ST beats carrying data, channel and framing.
module plazer_master_0_b2p #(
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  plazer_master_0_b2p_if.master bus
);

  localparam logic [7:0] SOP_CHAR  = 8'h7A;
  localparam logic [7:0] EOP_CHAR  = 8'h7B;
  localparam logic [7:0] CHAN_CHAR = 8'h7C;
  localparam logic [7:0] ESC_CHAR  = 8'h7D;
  localparam logic [7:0] ESC_XOR   = 8'h20;

  logic                     sop_flag, sop_nxt;
  logic                     eop_flag, eop_nxt;
  logic                     chan_flag, chan_nxt;
  logic                     esc_flag, esc_nxt;
  logic [CHANNEL_WIDTH-1:0] channel_reg, channel_nxt;

  logic                     out_valid_r;
  logic [7:0]               out_data_r;
  logic [CHANNEL_WIDTH-1:0] out_channel_r;
  logic                     out_sop_r;
  logic                     out_eop_r;

  logic                     accept;
  logic                     is_data;
  logic                     load;
  logic [7:0]               value;

  assign bus.in_ready          = !out_valid_r || bus.out_ready;
  assign accept                = bus.in_valid && bus.in_ready;

  assign bus.out_valid         = out_valid_r;
  assign bus.out_data          = out_data_r;
  assign bus.out_channel       = out_channel_r;
  assign bus.out_startofpacket = out_sop_r;
  assign bus.out_endofpacket   = out_eop_r;

  // An escaped byte is always ordinary data, even when it decodes to a control value.
  always_comb begin
    sop_nxt     = sop_flag;
    eop_nxt     = eop_flag;
    chan_nxt    = chan_flag;
    esc_nxt     = esc_flag;
    channel_nxt = channel_reg;
    value       = bus.in_data;
    is_data     = 1'b0;
    load        = 1'b0;

    if (accept) begin
      if (esc_flag) begin
        value   = bus.in_data ^ ESC_XOR;
        esc_nxt = 1'b0;
        is_data = 1'b1;
      end else begin
        case (bus.in_data)
          SOP_CHAR:  sop_nxt  = 1'b1;
          EOP_CHAR:  eop_nxt  = 1'b1;
          CHAN_CHAR: chan_nxt = 1'b1;
          ESC_CHAR:  esc_nxt  = 1'b1;
          default:   is_data  = 1'b1;
        endcase
      end
    end

    if (is_data) begin
      if (chan_flag) begin
        channel_nxt = CHANNEL_WIDTH'(value);
        chan_nxt    = 1'b0;
      end else begin
        load    = 1'b1;
        sop_nxt = 1'b0;
        eop_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sop_flag    <= 1'b0;
      eop_flag    <= 1'b0;
      chan_flag   <= 1'b0;
      esc_flag    <= 1'b0;
      channel_reg <= '0;
    end else begin
      sop_flag    <= sop_nxt;
      eop_flag    <= eop_nxt;
      chan_flag   <= chan_nxt;
      esc_flag    <= esc_nxt;
      channel_reg <= channel_nxt;
    end
  end

  // A transfer and a new load in the same cycle simply reload, so there is no bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r   <= 1'b0;
      out_data_r    <= '0;
      out_channel_r <= '0;
      out_sop_r     <= 1'b0;
      out_eop_r     <= 1'b0;
    end else if (load) begin
      out_valid_r   <= 1'b1;
      out_data_r    <= value;
      out_channel_r <= channel_reg;
      out_sop_r     <= sop_flag;
      out_eop_r     <= eop_flag;
    end else if (bus.out_ready) begin
      out_valid_r   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_plazer_master_0_b2p.sv
// Bench for plazer_master_0_b2p: byte tables with expected beats, a scoreboard queue
// and a monitor for handshake, stall stability and beat contents.
module tb_plazer_master_0_b2p;

  localparam int CW = 8;

  typedef struct {
    logic [7:0]    b;
    logic          beat;
    logic [7:0]    data;
    logic [CW-1:0] ch;
    logic          sop;
    logic          eop;
  } vec_t;

  logic clk;
  logic reset_n;

  plazer_master_0_b2p_if #(.CHANNEL_WIDTH(CW)) bus ();

  plazer_master_0_b2p #(.CHANNEL_WIDTH(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int unsigned   nvec = 0;
  int unsigned   nerr = 0;
  vec_t          tbl[$];
  logic [31:0]   sb[$];
  bit            mon_en = 1'b0;
  bit            p_stall = 1'b0;
  logic [31:0]   p_beat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endfunction

  function automatic vec_t mk(logic [7:0] b, logic beat, logic [7:0] d,
                              logic [CW-1:0] ch, logic s, logic e);
    vec_t v;
    v.b = b; v.beat = beat; v.data = d; v.ch = ch; v.sop = s; v.eop = e;
    return v;
  endfunction

  function automatic void ctl(logic [7:0] b);
    tbl.push_back(mk(b, 1'b0, 8'h00, '0, 1'b0, 1'b0));
  endfunction

  function automatic void dat(logic [7:0] b, logic [7:0] d, logic [CW-1:0] ch,
                              logic s, logic e);
    tbl.push_back(mk(b, 1'b1, d, ch, s, e));
  endfunction

  function automatic logic [31:0] pack_beat(logic [7:0] d, logic [CW-1:0] ch,
                                            logic s, logic e);
    return 32'({d, ch, s, e});
  endfunction

  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      chk("in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
      if (p_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_hold", pack_beat(bus.out_data, bus.out_channel,
                                    bus.out_startofpacket, bus.out_endofpacket), p_beat);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          chk("beat", pack_beat(bus.out_data, bus.out_channel,
                                bus.out_startofpacket, bus.out_endofpacket), sb.pop_front());
        end
      end
      p_stall = bus.out_valid && !bus.out_ready;
      p_beat  = pack_beat(bus.out_data, bus.out_channel,
                          bus.out_startofpacket, bus.out_endofpacket);
    end else begin
      p_stall = 1'b0;
    end
  end

  task automatic run_seq(input bit bp);
    bit acc;
    for (int unsigned i = 0; i < tbl.size(); i++) begin
      acc = 1'b0;
      for (int unsigned t = 0; t < 64 && !acc; t++) begin
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_data   = tbl[i].b;
        bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        if (!bp) begin
          chk("full_rate", 32'(bus.in_ready), 32'd1);
          if (i > 0) chk("latency", 32'(bus.out_valid), 32'(tbl[i-1].beat));
        end
        if (bus.in_ready) begin
          acc = 1'b1;
          if (tbl[i].beat)
            sb.push_back(pack_beat(tbl[i].data, tbl[i].ch, tbl[i].sop, tbl[i].eop));
        end
      end
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    if (!bp && tbl.size() > 0) chk("latency", 32'(bus.out_valid), 32'(tbl[tbl.size()-1].beat));
    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    tbl.delete();
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_channel", 32'(bus.out_channel), 32'd0);
    chk("rst_sop", 32'(bus.out_startofpacket), 32'd0);
    chk("rst_eop", 32'(bus.out_endofpacket), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs();
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // basic packet with channel select
    ctl(8'h7A); ctl(8'h7C); ctl(8'h03);
    dat(8'h11, 8'h11, 8'h03, 1'b1, 1'b0);
    dat(8'h22, 8'h22, 8'h03, 1'b0, 1'b0);
    ctl(8'h7B);
    dat(8'h33, 8'h33, 8'h03, 1'b0, 1'b1);
    run_seq(1'b0);

    // escapes of control values
    ctl(8'h7A); ctl(8'h7D);
    dat(8'h5A, 8'h7A, 8'h03, 1'b1, 1'b0);
    ctl(8'h7D);
    dat(8'h5D, 8'h7D, 8'h03, 1'b0, 1'b0);
    ctl(8'h7B); ctl(8'h7D);
    dat(8'h5C, 8'h7C, 8'h03, 1'b0, 1'b1);
    run_seq(1'b0);

    // escaped channel value, single-beat packet
    ctl(8'h7C); ctl(8'h7D); ctl(8'h5B); ctl(8'h7A); ctl(8'h7B);
    dat(8'h44, 8'h44, 8'h7B, 1'b1, 1'b1);
    run_seq(1'b0);

    // random backpressure, repeated a few times
    for (int unsigned r = 0; r < 4; r++) begin
      ctl(8'h7A);
      dat(8'h01, 8'h01, 8'h7B, 1'b1, 1'b0);
      dat(8'h02, 8'h02, 8'h7B, 1'b0, 1'b0);
      dat(8'h03, 8'h03, 8'h7B, 1'b0, 1'b0);
      ctl(8'h7B);
      dat(8'h04, 8'h04, 8'h7B, 1'b0, 1'b1);
      run_seq(1'b1);
    end

    // channel persistence across packets
    ctl(8'h7C); ctl(8'h05); ctl(8'h7A);
    dat(8'hAA, 8'hAA, 8'h05, 1'b1, 1'b0);
    ctl(8'h7B);
    dat(8'hBB, 8'hBB, 8'h05, 1'b0, 1'b1);
    ctl(8'h7A);
    dat(8'hCC, 8'hCC, 8'h05, 1'b1, 1'b0);
    ctl(8'h7B);
    dat(8'hDD, 8'hDD, 8'h05, 1'b0, 1'b1);
    // repeated markers, EOP before SOP
    ctl(8'h7B); ctl(8'h7A); ctl(8'h7A); ctl(8'h7B);
    dat(8'hEE, 8'hEE, 8'h05, 1'b1, 1'b1);
    // SOP while CHAN pending, then data without SOP
    ctl(8'h7C); ctl(8'h7A); ctl(8'h06);
    dat(8'h77, 8'h77, 8'h06, 1'b1, 1'b0);
    dat(8'h12, 8'h12, 8'h06, 1'b0, 1'b0);
    run_seq(1'b0);

    // reset in the middle of a packet header
    ctl(8'h7A); ctl(8'h7C);
    run_seq(1'b0);
    @(posedge clk); #1;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs();
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    sb.delete();
    dat(8'h09, 8'h09, 8'h00, 1'b0, 1'b0);
    ctl(8'h7B);
    dat(8'h0A, 8'h0A, 8'h00, 1'b0, 1'b1);
    run_seq(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
